// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART: serial input plus recovered byte and status strobes.
// The receiver sits on the slave modport; whatever drives the line and consumes bytes uses master.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    modport slave  (input  rx, output rx_data, rx_done, frame_err, rx_busy);
    modport master (output rx, input  rx_data, rx_done, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: single mid-bit sample per bit, no oversampling vote.
// Shares CLKS_PER_BIT with the transmitter so tx can be looped straight into rx.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_RECOVER
    } state_e;

    logic          sync1_q, rx_s_q, edge_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;
    logic [7:0]    data_q;
    logic          done_q, ferr_q, busy_q;

    logic          fall_d;
    logic [7:0]    sh_d;

    // Flops reset high so an idle line never looks like a start edge out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            edge_q  <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            rx_s_q  <= sync1_q;
            edge_q  <= rx_s_q;
        end
    end

    always_comb begin
        fall_d = edge_q & ~rx_s_q;
        sh_d   = {rx_s_q, sh_q[7:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fall_d) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                // Re-check the start bit at its middle; a high line here is a glitch.
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (!rx_s_q) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= S_DATA;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        sh_q  <= sh_d;
                        if (idx_q == 3'd7) state_q <= S_STOP;
                        else               idx_q   <= idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start.
                S_STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= sh_q;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_RECOVER;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Hold off until the line returns high so a break cannot spawn frames.
                S_RECOVER: begin
                    if (rx_s_q) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_done   = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = busy_q;
endmodule
